rt_jtag_dmi_tap: RTL
====================

// Module: rt_jtag_dmi_tap
// PURPOSE
// - JTAG TAP plus RISC-V debug transport module (spec 0.13 DTM). It is the target side of the JTAG debug link that the bench driver exercises.
// - Oversamples TCK/TMS/TDI in the clk domain, runs the 16-state TAP controller, and serves IDCODE, DTMCS, DMI and BYPASS.
// - Converts DMI scans into valid/ready requests toward the debug module, and returns responses on the next DMI capture.
// PARAMETERS
// IrLength    5             instruction register width
// IdCode      32'h00000DB3  IDCODE value; bit0 must be 1
// DmiAbits    7             DMI address width
// SyncStages  2             synchroniser depth for tck/tms/tdi/trst_n
// PORTS
// clk              in   1          system clock; must run >= 8x TCK
// rst_n            in   1          asynchronous, active-low reset
// tck_i            in   1          JTAG clock, asynchronous to clk
// tms_i            in   1          JTAG mode select
// tdi_i            in   1          JTAG data in
// trst_ni          in   1          JTAG reset, active-low, synchronised
// tdo_o            out  1          JTAG data out
// tdo_oe_o         out  1          high in Shift-IR / Shift-DR
// dmi_req_valid_o  out  1          DMI request valid
// dmi_req_ready_i  in   1          DMI request accepted
// dmi_req_addr_o   out  DmiAbits   DMI address
// dmi_req_op_o     out  2          1 = read, 2 = write
// dmi_req_data_o   out  32         DMI write data
// dmi_resp_valid_i in   1          DMI response valid
// dmi_resp_ready_o out  1          always 1 when no response is held
// dmi_resp_data_i  in   32         DMI read data
// dmi_resp_resp_i  in   2          0 = ok, 2 = failed
// dmi_hardrst_o    out  1          one-clk pulse on dtmcs.dmihardreset
// BEHAVIOUR
// - Reset values: all outputs 0, except dmi_resp_ready_o = 1. TAP state = Test-Logic-Reset, IR = IDCODE (5'h01), dmistat = 0.
// - Synchronisation and timing:
//   - Pins pass through SyncStages flops. TCK rise/fall is detected by comparison with the previous synchronised value.
//   - TAP action happens 1 clk after detection, i.e. SyncStages+1 clk after the pin edge.
// - TAP controller: standard 16-state machine, advanced on TCK rise from TMS.
//   - TMS = 1 for 5 rises reaches Test-Logic-Reset from any state.
//   - trst_ni low (synchronised) forces Test-Logic-Reset immediately.
//   - Test-Logic-Reset sets IR = IDCODE, clears the DMI shift register and clears dmistat. It does NOT drop an outstanding DMI request.
// - Capture/Shift/Update, on TCK rise:
//   - Capture loads the selected DR.
//   - Shift moves TDI in at the MSB and shifts right.
//   - Update latches the register.
//   - tdo_o presents the LSB and changes only on TCK fall.
//   - IR capture value is 5'b00001.
// - IR codes:
//   - 0x01: IDCODE, 32 bits.
//   - 0x10: DTMCS, 32 bits.
//   - 0x11: DMI, DmiAbits+34 bits.
//   - 0x1F and any other code: BYPASS, 1 bit, captures 0.
// - DTMCS read value: {14'b0, dmihardreset=0, dmireset=0, 1'b0, idle=3'd1, dmistat[1:0], abits=DmiAbits, version=4'd1}.
//   - Update with bit16 set clears dmistat.
//   - Update with bit17 set pulses dmi_hardrst_o, drops any pending request/response and clears dmistat.
// - DMI DR layout: {addr[DmiAbits+33:34], data[33:2], op[1:0]}.
//   - Capture loads {last addr, resp data, op}.
//   - Capture op = dmistat if nonzero; else 3 if a request is outstanding; else the last response code.
//   - If op = 3 is captured, dmistat becomes 3 (sticky).
// - DMI Update, only when dmistat = 0 and no request is outstanding:
//   - op 1 or 2 → dmi_req_valid_o = 1 on the next clk, holding addr/op/data stable until dmi_req_ready_i.
//   - op 0 or 3 → no request.
//   - If a request is outstanding or dmistat != 0, Update is ignored and dmistat = 3.
// - Response handshake: on dmi_resp_valid_i && dmi_resp_ready_o, latch data/resp and clear outstanding.
//   - resp 2 sets dmistat = 2 unless dmistat is already nonzero.
// - Simultaneous events: a request handshake and a TCK edge in the same clk are both processed. Reset via rst_n mid-request aborts everything.
// TESTING
// - trst pulse, IR = 0x01, 32-bit DR scan → TDO yields IdCode 0x00000DB3; IR scan captures 5'b00001.
// - IR = 0x1F, shift 0xA5 followed by one extra bit → TDO returns the stream delayed by one TCK, first bit 0.
// - DTMCS scan → reads 0x00001071; dmistat field = 0.
// - DMI write addr 0x10, data 0x00000001, op 2 → one req with addr 0x10, op 2, data 0x1. Stall ready for 3 clk → fields held stable.
// - DMI read addr 0x11 with resp 0x00030382/ok, then a nop scan → captured {0x11, 0x00030382, 0}.
// - DMI scan while a response is withheld → captured op 3, sticky. Next write is ignored (no req). DTMCS bit16 clears it → next write is issued.

Source files
------------

// File: rtl/rt_jtag_dmi_tap.sv
// JTAG TAP controller with a RISC-V 0.13 debug transport module (IDCODE, DTMCS, DMI, BYPASS).
// TCK/TMS/TDI/TRST are oversampled in the clk domain; DMI scans become valid/ready requests.
module rt_jtag_dmi_tap #(
    parameter int unsigned IrLength   = 5,
    parameter logic [31:0] IdCode     = 32'h00000DB3,
    parameter int unsigned DmiAbits   = 7,
    parameter int unsigned SyncStages = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tck_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    input  logic                trst_ni,
    output logic                tdo_o,
    output logic                tdo_oe_o,
    output logic                dmi_req_valid_o,
    input  logic                dmi_req_ready_i,
    output logic [DmiAbits-1:0] dmi_req_addr_o,
    output logic [1:0]          dmi_req_op_o,
    output logic [31:0]         dmi_req_data_o,
    input  logic                dmi_resp_valid_i,
    output logic                dmi_resp_ready_o,
    input  logic [31:0]         dmi_resp_data_i,
    input  logic [1:0]          dmi_resp_resp_i,
    output logic                dmi_hardrst_o
);

    localparam int unsigned DmiWidth = DmiAbits + 34;
    localparam logic [IrLength-1:0] IrIdcode = IrLength'(5'h01);
    localparam logic [IrLength-1:0] IrDtmcs  = IrLength'(5'h10);
    localparam logic [IrLength-1:0] IrDmi    = IrLength'(5'h11);

    typedef enum logic [3:0] {
        TlReset, RunIdle, SelDr, CapDr, ShDr, Ex1Dr, PauseDr, Ex2Dr, UpdDr,
        SelIr, CapIr, ShIr, Ex1Ir, PauseIr, Ex2Ir, UpdIr
    } tap_state_e;

    tap_state_e state_q, state_d;

    logic [SyncStages-1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
    logic                  tck_prev_q;
    logic                  tck_s, tms_s, tdi_s, trst_s;
    logic                  tck_rise_c, tck_fall_c;

    logic [IrLength-1:0] ir_q, ir_d, ir_sh_q, ir_sh_d;
    logic [DmiWidth-1:0] dr_q, dr_d;
    logic                tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
    logic [1:0]          dmistat_q, dmistat_d;
    logic                busy_q, busy_d;
    logic                req_valid_q, req_valid_d;
    logic [DmiAbits-1:0] req_addr_q, req_addr_d, last_addr_q, last_addr_d;
    logic [1:0]          req_op_q, req_op_d;
    logic [31:0]         req_data_q, req_data_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [1:0]          resp_code_q, resp_code_d;
    logic                resp_ready_q;
    logic                hardrst_q, hardrst_d;
    logic [1:0]          cap_op_c;
    logic [31:0]         dtmcs_c;

    // Pin synchronisers and TCK edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            trst_sync_q <= '0;
            tck_prev_q  <= 1'b0;
        end else begin
            tck_sync_q  <= {tck_sync_q[SyncStages-2:0], tck_i};
            tms_sync_q  <= {tms_sync_q[SyncStages-2:0], tms_i};
            tdi_sync_q  <= {tdi_sync_q[SyncStages-2:0], tdi_i};
            trst_sync_q <= {trst_sync_q[SyncStages-2:0], trst_ni};
            tck_prev_q  <= tck_s;
        end
    end

    assign tck_s      = tck_sync_q[SyncStages-1];
    assign tms_s      = tms_sync_q[SyncStages-1];
    assign tdi_s      = tdi_sync_q[SyncStages-1];
    assign trst_s     = trst_sync_q[SyncStages-1];
    assign tck_rise_c = tck_s & ~tck_prev_q;
    assign tck_fall_c = ~tck_s & tck_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= TlReset;
        else        state_q <= state_d;
    end

    // TAP next-state, advanced by TMS on each synchronised TCK rise
    always_comb begin
        state_d = state_q;
        if (!trst_s) begin
            state_d = TlReset;
        end else if (tck_rise_c) begin
            case (state_q)
                TlReset: state_d = tms_s ? TlReset : RunIdle;
                RunIdle: state_d = tms_s ? SelDr   : RunIdle;
                SelDr:   state_d = tms_s ? SelIr   : CapDr;
                CapDr:   state_d = tms_s ? Ex1Dr   : ShDr;
                ShDr:    state_d = tms_s ? Ex1Dr   : ShDr;
                Ex1Dr:   state_d = tms_s ? UpdDr   : PauseDr;
                PauseDr: state_d = tms_s ? Ex2Dr   : PauseDr;
                Ex2Dr:   state_d = tms_s ? UpdDr   : ShDr;
                UpdDr:   state_d = tms_s ? SelDr   : RunIdle;
                SelIr:   state_d = tms_s ? TlReset : CapIr;
                CapIr:   state_d = tms_s ? Ex1Ir   : ShIr;
                ShIr:    state_d = tms_s ? Ex1Ir   : ShIr;
                Ex1Ir:   state_d = tms_s ? UpdIr   : PauseIr;
                PauseIr: state_d = tms_s ? Ex2Ir   : PauseIr;
                Ex2Ir:   state_d = tms_s ? UpdIr   : ShIr;
                UpdIr:   state_d = tms_s ? SelDr   : RunIdle;
                default: state_d = TlReset;
            endcase
        end
    end

    // A pending request reads back as busy (3) unless an error is already latched
    assign cap_op_c = (dmistat_q != 2'd0) ? dmistat_q : (busy_q ? 2'd3 : resp_code_q);
    assign dtmcs_c  = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat_q, 6'(DmiAbits), 4'd1};

    // Register datapath, DMI handshakes and DTM state
    always_comb begin
        ir_d        = ir_q;
        ir_sh_d     = ir_sh_q;
        dr_d        = dr_q;
        tdo_d       = tdo_q;
        tdo_oe_d    = (state_q == ShIr) || (state_q == ShDr);
        dmistat_d   = dmistat_q;
        busy_d      = busy_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_op_d    = req_op_q;
        req_data_d  = req_data_q;
        last_addr_d = last_addr_q;
        resp_data_d = resp_data_q;
        resp_code_d = resp_code_q;
        hardrst_d   = 1'b0;

        if (req_valid_q && dmi_req_ready_i) begin
            req_valid_d = 1'b0;
        end
        if (dmi_resp_valid_i && resp_ready_q) begin
            resp_data_d = dmi_resp_data_i;
            resp_code_d = dmi_resp_resp_i;
            busy_d      = 1'b0;
            if (dmi_resp_resp_i == 2'd2 && dmistat_q == 2'd0) begin
                dmistat_d = 2'd2;
            end
        end

        if (tck_fall_c) begin
            if (state_q == ShIr)      tdo_d = ir_sh_q[0];
            else if (state_q == ShDr) tdo_d = dr_q[0];
        end

        // Test-Logic-Reset leaves any outstanding DMI request in flight
        if (state_q == TlReset) begin
            ir_d      = IrIdcode;
            dr_d      = '0;
            dmistat_d = 2'd0;
        end else if (tck_rise_c && trst_s) begin
            case (state_q)
                CapIr: ir_sh_d = IrLength'(1);
                ShIr:  ir_sh_d = {tdi_s, ir_sh_q[IrLength-1:1]};
                UpdIr: ir_d    = ir_sh_q;
                CapDr: begin
                    case (ir_q)
                        IrIdcode: dr_d = DmiWidth'(IdCode);
                        IrDtmcs:  dr_d = DmiWidth'(dtmcs_c);
                        IrDmi: begin
                            dr_d = {last_addr_q, resp_data_q, cap_op_c};
                            if (cap_op_c == 2'd3) dmistat_d = 2'd3;
                        end
                        default:  dr_d = '0;
                    endcase
                end
                ShDr: begin
                    case (ir_q)
                        IrIdcode, IrDtmcs: dr_d = DmiWidth'({tdi_s, dr_q[31:1]});
                        IrDmi:             dr_d = {tdi_s, dr_q[DmiWidth-1:1]};
                        default:           dr_d = DmiWidth'(tdi_s);
                    endcase
                end
                UpdDr: begin
                    if (ir_q == IrDtmcs) begin
                        if (dr_q[17]) begin
                            hardrst_d   = 1'b1;
                            req_valid_d = 1'b0;
                            busy_d      = 1'b0;
                            dmistat_d   = 2'd0;
                        end else if (dr_q[16]) begin
                            dmistat_d = 2'd0;
                        end
                    end else if (ir_q == IrDmi) begin
                        if (dmistat_q != 2'd0 || busy_q) begin
                            dmistat_d = 2'd3;
                        end else if (dr_q[1:0] == 2'd1 || dr_q[1:0] == 2'd2) begin
                            req_valid_d = 1'b1;
                            req_addr_d  = dr_q[DmiWidth-1:34];
                            req_data_d  = dr_q[33:2];
                            req_op_d    = dr_q[1:0];
                            last_addr_d = dr_q[DmiWidth-1:34];
                            busy_d      = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q         <= IrIdcode;
            ir_sh_q      <= '0;
            dr_q         <= '0;
            tdo_q        <= 1'b0;
            tdo_oe_q     <= 1'b0;
            dmistat_q    <= 2'd0;
            busy_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            req_op_q     <= 2'd0;
            req_data_q   <= '0;
            last_addr_q  <= '0;
            resp_data_q  <= '0;
            resp_code_q  <= 2'd0;
            resp_ready_q <= 1'b1;
            hardrst_q    <= 1'b0;
        end else begin
            ir_q         <= ir_d;
            ir_sh_q      <= ir_sh_d;
            dr_q         <= dr_d;
            tdo_q        <= tdo_d;
            tdo_oe_q     <= tdo_oe_d;
            dmistat_q    <= dmistat_d;
            busy_q       <= busy_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            req_op_q     <= req_op_d;
            req_data_q   <= req_data_d;
            last_addr_q  <= last_addr_d;
            resp_data_q  <= resp_data_d;
            resp_code_q  <= resp_code_d;
            resp_ready_q <= 1'b1;
            hardrst_q    <= hardrst_d;
        end
    end

    assign tdo_o            = tdo_q;
    assign tdo_oe_o         = tdo_oe_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_addr_o   = req_addr_q;
    assign dmi_req_op_o     = req_op_q;
    assign dmi_req_data_o   = req_data_q;
    assign dmi_resp_ready_o = resp_ready_q;
    assign dmi_hardrst_o    = hardrst_q;

endmodule
